// File: rtl/ddr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// ddr_wr_arbiter
//
// Shares one DDR write-burst port between two burst writers in the mem_clk
// domain. Port 0 is the video capture writer and port 1 is the overlay/rectangle
// writer. Each writer sees the same req / data_req / finish handshake it would
// see from the memory controller directly.
//
// A grant is held for a whole burst. Every burst, including a zero-length
// request, is followed by a one-cycle release gap. A zero-length request is
// answered locally with a finish pulse, and no DDR burst is issued for it.
// Data-beat overruns are flagged with a sticky error bit.
//
// Build option:
//   ARB_RR_EN  defined   : round-robin arbitration. A tie goes to the pointer's
//                          port. The pointer moves past each winner.
//              undefined : fixed priority. Port 0 wins ties, and no pointer
//                          logic is built.
//
// Ports:
//   mem_clk, rst                      clock and synchronous active-high reset
//   pN_wr_burst_req/addr/len/data     burst request from writer N
//   pN_wr_burst_data_req              data strobe routed to writer N
//   pN_burst_finish                   burst-complete pulse to writer N
//   wr_burst_req/addr/len/data        burst request to the DDR controller
//   wr_burst_data_req, burst_finish   strobes from the DDR controller
//   grant                             one-hot current owner, 00 when idle
//   overrun_err                       sticky: more beats than granted length
// -----------------------------------------------------------------------------
module ddr_wr_arbiter #(
   parameter logic [9:0] MAX_LEN = 10'd128
) (
   input  logic        mem_clk,
   input  logic        rst,
   // port 0 (video capture)
   input  logic        p0_wr_burst_req,
   input  logic [26:0] p0_wr_burst_addr,
   input  logic [9:0]  p0_wr_burst_len,
   input  logic [63:0] p0_wr_burst_data,
   output logic        p0_wr_burst_data_req,
   output logic        p0_burst_finish,
   // port 1 (overlay / rectangle)
   input  logic        p1_wr_burst_req,
   input  logic [26:0] p1_wr_burst_addr,
   input  logic [9:0]  p1_wr_burst_len,
   input  logic [63:0] p1_wr_burst_data,
   output logic        p1_wr_burst_data_req,
   output logic        p1_burst_finish,
   // DDR controller side
   output logic        wr_burst_req,
   output logic [26:0] wr_burst_addr,
   output logic [9:0]  wr_burst_len,
   output logic [63:0] wr_burst_data,
   input  logic        wr_burst_data_req,
   input  logic        burst_finish,
   // status
   output logic [1:0]  grant,
   output logic        overrun_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOCK = 2'd1,
      BUSY = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;      // 0: port 0, 1: port 1
   logic [26:0] addr_q, addr_d;
   logic [9:0]  len_q, len_d;
   logic [1:0]  grant_q, grant_d;
   logic        req_q, req_d;
   logic [9:0]  cnt_q, cnt_d;
   logic        ovr_q, ovr_d;
   logic [1:0]  zl_fin_q, zl_fin_d;    // finish pulse for zero-length requests

`ifdef ARB_RR_EN
   logic        ptr_q, ptr_d;          // port that wins the next tie
`endif

   logic        any_req;
   logic        winner;
   logic [26:0] win_addr;
   logic [9:0]  win_len;
   logic        fwd_en;

   function automatic logic [9:0] clamp_len(input logic [9:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   assign any_req = p0_wr_burst_req | p1_wr_burst_req;

`ifdef ARB_RR_EN
   always_comb begin
      if (p0_wr_burst_req && p1_wr_burst_req) begin
         winner = ptr_q;
      end else begin
         winner = p1_wr_burst_req;
      end
   end
`else
   // Port 1 wins only when port 0 is not asking.
   assign winner = ~p0_wr_burst_req & p1_wr_burst_req;
`endif

   assign win_addr = winner ? p1_wr_burst_addr : p0_wr_burst_addr;
   assign win_len  = winner ? p1_wr_burst_len  : p0_wr_burst_len;

   // ---------------------------------------------------------------------------
   // Next-state and datapath control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      len_d    = len_q;
      grant_d  = grant_q;
      req_d    = req_q;
      cnt_d    = cnt_q;
      ovr_d    = ovr_q;
      zl_fin_d = 2'b00;
`ifdef ARB_RR_EN
      ptr_d    = ptr_q;
`endif

      case (state_q)
         IDLE: begin
            if (any_req) begin
               if (win_len == 10'd0) begin
                  // Zero-length requests are answered locally and still pass
                  // through GAP, so the held req is not seen again.
                  zl_fin_d = winner ? 2'b10 : 2'b01;
                  state_d  = GAP;
`ifdef ARB_RR_EN
                  ptr_d    = ~winner;
`endif
               end else begin
                  owner_d = winner;
                  addr_d  = win_addr;
                  len_d   = clamp_len(win_len);
                  grant_d = winner ? 2'b10 : 2'b01;
                  state_d = LOCK;
               end
            end
         end

         LOCK: begin
            req_d   = 1'b1;
            cnt_d   = 10'd0;
            state_d = BUSY;
         end

         BUSY: begin
            if (wr_burst_data_req) begin
               req_d = 1'b0;
               // The beat is forwarded even when it exceeds the length.
               if (cnt_q == len_q) begin
                  ovr_d = 1'b1;
               end
               if (cnt_q != 10'h3FF) begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
            if (burst_finish) begin
               req_d   = 1'b0;
               grant_d = 2'b00;
               state_d = GAP;
`ifdef ARB_RR_EN
               ptr_d   = ~owner_q;
`endif
            end
         end

         GAP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         addr_q   <= 27'd0;
         len_q    <= 10'd0;
         grant_q  <= 2'b00;
         req_q    <= 1'b0;
         cnt_q    <= 10'd0;
         ovr_q    <= 1'b0;
         zl_fin_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         grant_q  <= grant_d;
         req_q    <= req_d;
         cnt_q    <= cnt_d;
         ovr_q    <= ovr_d;
         zl_fin_q <= zl_fin_d;
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Outputs: strobes and write data are steered with no added latency, and
   // only while a burst is in flight.
   // ---------------------------------------------------------------------------
   assign fwd_en = (state_q == BUSY);

   assign p0_wr_burst_data_req = fwd_en & grant_q[0] & wr_burst_data_req;
   assign p1_wr_burst_data_req = fwd_en & grant_q[1] & wr_burst_data_req;
   assign p0_burst_finish      = (fwd_en & grant_q[0] & burst_finish) | zl_fin_q[0];
   assign p1_burst_finish      = (fwd_en & grant_q[1] & burst_finish) | zl_fin_q[1];

   assign wr_burst_data = !fwd_en ? 64'd0 :
                          (owner_q ? p1_wr_burst_data : p0_wr_burst_data);

   assign wr_burst_req  = req_q;
   assign wr_burst_addr = addr_q;
   assign wr_burst_len  = len_q;
   assign grant         = grant_q;
   assign overrun_err   = ovr_q;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr_wr_arbiter
//
// Directed bench for ddr_wr_arbiter. It has two parts:
//   - A cycle table of {inputs, expected outputs}. The table covers a short
//     port-1 burst, strobes arriving outside a burst, a zero-length request,
//     and a port-0 burst that follows on immediately.
//   - Hand-written sequences for the longer corner cases: a 16-beat burst,
//     ties, clamping with a held request, overrun, and reset in mid-burst.
//
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_ddr_wr_arbiter;

   logic        clk;
   logic        rst;
   logic        p0_req, p1_req;
   logic [26:0] p0_addr, p1_addr;
   logic [9:0]  p0_len, p1_len;
   logic [63:0] p0_data, p1_data;
   logic        p0_dreq, p1_dreq, p0_fin, p1_fin;
   logic        wr_req;
   logic [26:0] wr_addr;
   logic [9:0]  wr_len;
   logic [63:0] wr_data;
   logic        ddr_dreq, ddr_fin;
   logic [1:0]  grant;
   logic        overrun;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [26:0] P0_ADDR = 27'h0000ABC;
   localparam logic [26:0] P1_ADDR = 27'h0123456;
   localparam logic [63:0] P0_DATA = 64'hA5A5_0000_0000_0001;
   localparam logic [63:0] P1_DATA = 64'h5A5A_FFFF_0000_0002;

   ddr_wr_arbiter dut (
      .mem_clk              (clk),
      .rst                  (rst),
      .p0_wr_burst_req      (p0_req),
      .p0_wr_burst_addr     (p0_addr),
      .p0_wr_burst_len      (p0_len),
      .p0_wr_burst_data     (p0_data),
      .p0_wr_burst_data_req (p0_dreq),
      .p0_burst_finish      (p0_fin),
      .p1_wr_burst_req      (p1_req),
      .p1_wr_burst_addr     (p1_addr),
      .p1_wr_burst_len      (p1_len),
      .p1_wr_burst_data     (p1_data),
      .p1_wr_burst_data_req (p1_dreq),
      .p1_burst_finish      (p1_fin),
      .wr_burst_req         (wr_req),
      .wr_burst_addr        (wr_addr),
      .wr_burst_len         (wr_len),
      .wr_burst_data        (wr_data),
      .wr_burst_data_req    (ddr_dreq),
      .burst_finish         (ddr_fin),
      .grant                (grant),
      .overrun_err          (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic       p0r;
      logic [9:0] p0l;
      logic       p1r;
      logic [9:0] p1l;
      logic       dreq;
      logic       fin;
      logic       e_wr;
      logic [1:0] e_grant;
      logic [1:0] e_dreq;   // {p1, p0}
      logic [1:0] e_fin;    // {p1, p0}
      logic [9:0] e_len;
      logic [1:0] e_dsel;   // 0: zero, 1: port 0 data, 2: port 1 data
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   function automatic logic [63:0] dsel_data(input logic [1:0] s);
      case (s)
         2'd1:    return P0_DATA;
         2'd2:    return P1_DATA;
         default: return 64'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      p0_req = 1'b0; p1_req = 1'b0;
      p0_len = 10'd0; p1_len = 10'd0;
      p0_addr = P0_ADDR; p1_addr = P1_ADDR;
      p0_data = P0_DATA; p1_data = P1_DATA;
      ddr_dreq = 1'b0; ddr_fin = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic wait_wr_req(input string name, input int max_cyc, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         #1;
         if (wr_req) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: wr_burst_req not seen within %0d cycles", name, max_cyc);
      end
   endtask

   task automatic beat(input logic d, input logic f);
      @(negedge clk);
      ddr_dreq = d;
      ddr_fin  = f;
      #1;
   endtask

   initial begin
      logic       ok;
      int         cnt_dreq, cnt_fin, p0_any, bad;
      logic [1:0] exp_tie [4];

      rst = 1'b1;
      clear_inputs();
      repeat (3) @(negedge clk);

      // ---------------- reset state ----------------
      rst = 1'b0;
      #1;
      chk("reset_state",
          {wr_req, wr_addr, wr_len, wr_data, grant, overrun, p0_dreq, p1_dreq, p0_fin, p1_fin},
          128'd0);

      // ---------------- cycle table ----------------
      //            p0r   p0l     p1r   p1l    dreq  fin  | wr   grant  dreq   fin    len    dsel
      vecs[0]  = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 10'd0, 2'd0};
      vecs[1]  = '{1'b0, 10'd0, 1'b1, 10'd3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 10'd0, 2'd0};
      vecs[2]  = '{1'b0, 10'd0, 1'b1, 10'd3, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 10'd3, 2'd0};
      vecs[3]  = '{1'b0, 10'd0, 1'b1, 10'd3, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 10'd3, 2'd2};
      vecs[4]  = '{1'b0, 10'd0, 1'b0, 10'd3, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 10'd3, 2'd2};
      vecs[5]  = '{1'b0, 10'd0, 1'b0, 10'd3, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 10'd3, 2'd2};
      vecs[6]  = '{1'b0, 10'd0, 1'b0, 10'd3, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 10'd3, 2'd2};
      vecs[7]  = '{1'b0, 10'd0, 1'b0, 10'd3, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 10'd3, 2'd2};
      vecs[8]  = '{1'b0, 10'd0, 1'b1, 10'd7, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 10'd3, 2'd0};
      vecs[9]  = '{1'b0, 10'd0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 10'd3, 2'd0};
      vecs[10] = '{1'b0, 10'd0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 10'd3, 2'd0};
      vecs[11] = '{1'b1, 10'd2, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 10'd3, 2'd0};
      vecs[12] = '{1'b1, 10'd2, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 10'd2, 2'd0};
      vecs[13] = '{1'b1, 10'd2, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 10'd2, 2'd1};
      vecs[14] = '{1'b0, 10'd2, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 10'd2, 2'd1};
      vecs[15] = '{1'b0, 10'd2, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 10'd2, 2'd1};
      vecs[16] = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 10'd2, 2'd0};
      vecs[17] = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 10'd2, 2'd0};

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         p0_req   = vecs[i].p0r;
         p0_len   = vecs[i].p0l;
         p1_req   = vecs[i].p1r;
         p1_len   = vecs[i].p1l;
         ddr_dreq = vecs[i].dreq;
         ddr_fin  = vecs[i].fin;
         #1;
         chk($sformatf("vec%0d", i),
             {wr_req, grant, p1_dreq, p0_dreq, p1_fin, p0_fin, wr_len, overrun, wr_data},
             {vecs[i].e_wr, vecs[i].e_grant, vecs[i].e_dreq, vecs[i].e_fin,
              vecs[i].e_len, 1'b0, dsel_data(vecs[i].e_dsel)});
      end

      // ---------------- single 16-beat burst on port 1 ----------------
      do_reset();
      @(negedge clk);
      p1_req = 1'b1; p1_len = 10'd16; p1_addr = P1_ADDR;
      #1;
      @(negedge clk); #1;
      chk("lat_t1_req", wr_req, 1'b0);
      @(negedge clk); #1;
      chk("lat_t2_req_addr_len", {wr_req, grant, wr_addr, wr_len}, {1'b1, 2'b10, P1_ADDR, 10'd16});
      cnt_dreq = 0; cnt_fin = 0; p0_any = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ddr_dreq = 1'b1;
         p1_req   = 1'b0;
         #1;
         if (p1_dreq) cnt_dreq++;
         if (p1_fin) cnt_fin++;
         if (p0_dreq || p0_fin) p0_any++;
         if (i == 5) chk("burst_data_mux", wr_data, P1_DATA);
      end
      beat(1'b0, 1'b1);
      if (p1_fin) cnt_fin++;
      if (p0_dreq || p0_fin) p0_any++;
      beat(1'b0, 1'b0);
      if (p1_fin) cnt_fin++;
      if (p0_dreq || p0_fin) p0_any++;
      chk("burst_p1_dreq_count", cnt_dreq, 16);
      chk("burst_p1_fin_count", cnt_fin, 1);
      chk("burst_p0_quiet", p0_any, 0);

      // ---------------- tie for 4 bursts ----------------
`ifdef ARB_RR_EN
      exp_tie[0] = 2'b01; exp_tie[1] = 2'b10; exp_tie[2] = 2'b01; exp_tie[3] = 2'b10;
`else
      exp_tie[0] = 2'b01; exp_tie[1] = 2'b01; exp_tie[2] = 2'b01; exp_tie[3] = 2'b01;
`endif
      do_reset();
      p0_req = 1'b1; p0_len = 10'd1;
      p1_req = 1'b1; p1_len = 10'd1;
      for (int b = 0; b < 4; b++) begin
         wait_wr_req($sformatf("tie%0d_wait", b), 20, ok);
         if (ok) chk($sformatf("tie%0d_grant", b), grant, exp_tie[b]);
         beat(1'b1, 1'b0);
         beat(1'b0, 1'b1);
         beat(1'b0, 1'b0);
      end
      p0_req = 1'b0; p1_req = 1'b0;

      // ---------------- clamp and held request after finish ----------------
      do_reset();
      p0_req = 1'b1; p0_len = 10'd200;
      wait_wr_req("clamp_wait", 20, ok);
      if (ok) chk("clamp_len", {grant, wr_len}, {2'b01, 10'd128});
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b1);
      beat(1'b0, 1'b0);          // GAP with req still high
      @(negedge clk);
      p0_req = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (wr_req || grant != 2'b00) bad++;
      end
      chk("clamp_no_regrant", bad, 0);

      // ---------------- overrun ----------------
      do_reset();
      p0_req = 1'b1; p0_len = 10'd4;
      wait_wr_req("ovr_wait", 20, ok);
      p0_req = 1'b0;
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);          // 5th beat
      chk("ovr_5th_fwd_clear", {p0_dreq, overrun}, {1'b1, 1'b0});
      beat(1'b0, 1'b1);
      chk("ovr_set", overrun, 1'b1);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b0);
      chk("ovr_sticky", overrun, 1'b1);
      do_reset();
      chk("ovr_cleared_by_rst", overrun, 1'b0);

      // ---------------- reset in mid-burst ----------------
      p1_req = 1'b1; p1_len = 10'd8;
      wait_wr_req("rstmid_wait", 20, ok);
      p1_req = 1'b0;
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);
      @(negedge clk);
      ddr_dreq = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid_dropped", {wr_req, grant, p1_fin, p0_fin}, 5'd0);
      p0_req = 1'b1; p0_len = 10'd1;
      wait_wr_req("resume_wait", 20, ok);
      if (ok) chk("resume_grant", {grant, wr_addr}, {2'b01, P0_ADDR});
      p0_req = 1'b0;
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b1);
      beat(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
